// File: rtl/alu_array_pkg.sv
// alu_array_pkg: shared opcode definitions for the multi-lane ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Contents:
//   OP_W  - opcode width per lane
//   op_e  - opcode enum, members OP_ADD .. OP_CLR double as the opcode constants
package alu_array_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,  // a + b
        OP_SUB  = 3'b001,  // a - b, carry = borrow
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ACC  = 3'b110,  // acc <= acc + a, result = new acc
        OP_CLR  = 3'b111   // acc <= 0, result = 0
    } op_e;

endpackage

// File: rtl/alu_array_if.sv
// alu_array_if: bundles the operand (input) and result (output) handshakes.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready flow control.
//
// Signals (lane i of a packed bus sits at [i*WIDTH +: WIDTH], op at [i*OP_W +: OP_W]):
//   in_valid/in_ready, a, b, op          - operand bundle towards the ALU
//   out_valid/out_ready, result, carry,
//   zero                                 - result bundle from the ALU
// Modports: master = producer/consumer side (testbench, pin mapping),
//           slave  = the ALU array itself.
interface alu_array_if
    import alu_array_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
);

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*WIDTH-1:0]  a;
    logic [NUM_CH*WIDTH-1:0]  b;
    logic [NUM_CH*OP_W-1:0]   op;

    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*WIDTH-1:0]  result;
    logic [NUM_CH-1:0]        carry;
    logic [NUM_CH-1:0]        zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero
    );

endinterface

// File: rtl/alu_lane.sv
// alu_lane: one lane's opcode decode, flag generation and result register (stage S2).
// Latency: 1 cycle from the S1 operand registers to the registered result/flags.
// Backpressure: state (result, flags, accumulator) only changes when adv is high.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   adv               - S1->S2 advance: capture new result and update accumulator
//   a, b, op          - operands and opcode from the S1 registers
//   result, carry,
//   zero              - registered lane outputs
// Build option: ALU_ARRAY_ACC_EN adds the per-lane accumulator used by OP_ACC/OP_CLR;
// without it those opcodes yield result=0, carry=0, zero=1.
module alu_lane
    import alu_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    // Widened by one bit so the top bit is the carry (ADD) or borrow (SUB).
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

`ifdef ALU_ARRAY_ACC_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]   acc_ext;

    assign acc_ext = {1'b0, acc} + {1'b0, a};
`endif

    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
`ifdef ALU_ARRAY_ACC_EN
        acc_nxt   = acc;
`endif
        case (op_e'(op))
            OP_ADD: begin
                res_nxt   = sum_ext[WIDTH-1:0];
                carry_nxt = sum_ext[WIDTH];
            end
            OP_SUB: begin
                res_nxt   = diff_ext[WIDTH-1:0];
                carry_nxt = diff_ext[WIDTH];
            end
            OP_AND:  res_nxt = a & b;
            OP_OR:   res_nxt = a | b;
            OP_XOR:  res_nxt = a ^ b;
            OP_XNOR: res_nxt = ~(a ^ b);
`ifdef ALU_ARRAY_ACC_EN
            OP_ACC: begin
                acc_nxt   = acc_ext[WIDTH-1:0];
                res_nxt   = acc_ext[WIDTH-1:0];
                carry_nxt = acc_ext[WIDTH];
            end
            OP_CLR: acc_nxt = '0;
`endif
            // Without the accumulator, OP_ACC/OP_CLR fall here and keep the zero defaults.
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else if (adv) begin
            result <= res_nxt;
            carry  <= carry_nxt;
            zero   <= (res_nxt == '0);
        end
    end

`ifdef ALU_ARRAY_ACC_EN
    // Updated in the same edge that moves the bundle into S2, so a following ACC
    // sitting in S1 already sees the new value: back-to-back ACCs chain cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (adv) begin
            acc <= acc_nxt;
        end
    end
`endif

endmodule

// File: rtl/alu_array.sv
// alu_array: NUM_CH-lane ALU behind a two-stage (S1 operands, S2 results) pipeline.
// Latency: 2 register stages from operand capture to out_valid; 1 bundle/cycle throughput.
// Backpressure: full valid/ready; a stalled S2 holds its outputs and S1 holds once full.
//
// Ports:
//   wb_clk_i  - clock, all state on the rising edge
//   wb_rst_i  - asynchronous active-high reset; discards in-flight bundles
//   bus       - alu_array_if slave modport (operand and result handshakes)
// Build option: ALU_ARRAY_ACC_EN enables the per-lane accumulators (see alu_lane).
module alu_array
    import alu_array_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    alu_array_if.slave  bus
);

    logic                    s1_valid;
    logic                    s2_valid;
    logic [NUM_CH*WIDTH-1:0] s1_a;
    logic [NUM_CH*WIDTH-1:0] s1_b;
    logic [NUM_CH*OP_W-1:0]  s1_op;

    logic                    s2_adv;
    logic                    s1_adv;
    logic                    s1_load;
    logic                    s2_load;

    logic [NUM_CH*WIDTH-1:0] lane_result;
    logic [NUM_CH-1:0]       lane_carry;
    logic [NUM_CH-1:0]       lane_zero;

    // Ready ripples back from the output; in_valid never feeds in_ready.
    assign s2_adv  = !s2_valid || bus.out_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign s1_load = bus.in_valid && s1_adv;
    // Only a real bundle moving S1->S2 touches lane state, so outputs hold
    // their last value once the pipe drains.
    assign s2_load = s1_valid && s2_adv;

    assign bus.in_ready = s1_adv;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (s1_load) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= bus.op;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        alu_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .adv    (s2_load),
            .a      (s1_a[i*WIDTH +: WIDTH]),
            .b      (s1_b[i*WIDTH +: WIDTH]),
            .op     (s1_op[i*OP_W +: OP_W]),
            .result (lane_result[i*WIDTH +: WIDTH]),
            .carry  (lane_carry[i]),
            .zero   (lane_zero[i])
        );
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = lane_result;
    assign bus.carry     = lane_carry;
    assign bus.zero      = lane_zero;

    // A stalled result must stay put until the consumer takes it.
    a_stall_hold : assert property (
        @(posedge wb_clk_i) disable iff (wb_rst_i)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.result) && $stable(bus.carry) && $stable(bus.zero))
    );

endmodule
